fixed_to_float_seq: RTL and testbench
=====================================

FIXED_TO_FLOAT_SEQ -- requirements
Module: fixed_to_float_seq

Interface
REQ-001 Parameter SHALL be: FRAC_BITS, 26, number of fractional bits in FIXED; legal range 0..31.
REQ-002 Port SHALL be: CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 Port SHALL be: RST_FF  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 Port SHALL be: Begin_FSM_FF  input  1  conversion request, level, sampled only in IDLE.
REQ-005 Port SHALL be: FIXED  input  32  two's-complement fixed-point operand, FRAC_BITS fraction bits.
REQ-006 Port SHALL be: ACK_FF  output  1  conversion done, registered, high only in DONE.
REQ-007 Port SHALL be: RESULT  output  32  IEEE-754 single-precision result, registered.

Function
REQ-008 The FSM SHALL have states IDLE, ABS, NORM, ROUND and DONE.
REQ-009 IDLE: on an edge with Begin_FSM_FF=1, SHALL capture FIXED into an operand register and go to ABS; otherwise stay.
REQ-010 ABS: SHALL register sign=op[31] and a 32-bit unsigned magnitude mag = sign ? -op : op, so 0x80000000 gives mag 0x80000000; SHALL clear the lz counter.
REQ-011 ABS, mag==0: SHALL write RESULT=0x00000000 (+0, never -0) and go to DONE.
REQ-012 ABS, mag!=0: SHALL go to NORM.
REQ-013 NORM: while mag[31]==0, SHALL shift mag left by 1 and increment lz (6-bit) once per cycle.
REQ-014 NORM: when mag[31]==1, SHALL go to ROUND with no shift.
REQ-015 ROUND: exponent SHALL be 127 + (31 - lz) - FRAC_BITS, always within 96..159; no overflow, underflow, denormal, Inf or NaN is generated.
REQ-016 ROUND: mantissa SHALL be mag[30:8], guard=mag[7], sticky=OR(mag[6:0]).
REQ-017 ROUND: rounding SHALL be round-to-nearest-even; increment when guard && (sticky || mant[0]).
REQ-018 ROUND: on mantissa carry-out, mantissa SHALL become 0 and exponent SHALL increment by 1.
REQ-019 ROUND: SHALL write RESULT={sign, exp[7:0], mant[22:0]} and go to DONE.
REQ-020 DONE: ACK_FF SHALL be 1; stay while Begin_FSM_FF=1, go to IDLE on the first edge with Begin_FSM_FF=0.
REQ-021 Four-phase handshake: a Begin level held high through DONE SHALL NOT start a second conversion.
REQ-022 Latency for nonzero input: Begin sampled at edge k; ACK_FF SHALL rise at edge k+3+lz (lz = 0..31, max k+34).
REQ-023 Latency for zero input: ACK_FF SHALL rise at edge k+2.
REQ-024 Changes on FIXED or Begin_FSM_FF outside IDLE/DONE SHALL be ignored.
REQ-025 RESULT SHALL hold its value until the next ABS (zero) or ROUND write, including through IDLE.

Reset
REQ-026 RST_FF=1 at an edge SHALL force IDLE, ACK_FF=0, RESULT=0x00000000, and operand, sign, mag and lz to 0.
REQ-027 Reset SHALL take priority over every transition and SHALL abort a conversion in progress without updating RESULT.
REQ-028 After reset is released, IDLE SHALL accept Begin_FSM_FF on the very next edge.

Verification (FRAC_BITS=26)
REQ-029 FIXED=0x04000000 (1.0), pulse Begin -> RESULT=0x3F800000, lz=5, ACK at k+8.
REQ-030 FIXED=0xFC000000 -> 0xBF800000; FIXED=0x80000000 -> 0xC2000000 with ACK at k+3.
REQ-031 FIXED=0x00000000 -> RESULT=0x00000000 with ACK at k+2.
REQ-032 Rounding cases:
- 0x40000040 (tie, even) -> 0x41800000.
- 0x400000C0 (tie, odd) -> 0x41800002.
- 0x7FFFFFFF (carry-out) -> 0x42000000.
- 0x00000001 -> 0x32800000.
REQ-033 Handshake: Begin held high for 50 cycles -> exactly one conversion, and ACK stays high until the edge after Begin falls.
REQ-034 Reset mid-operation: RST_FF during NORM for FIXED=0x00000001 -> IDLE, ACK=0, RESULT=0; a following conversion is correct.

Source files
------------

// File: rtl/fixed_to_float_seq.sv
// fixed_to_float_seq
//   Multi-cycle converter from a 32-bit two's-complement fixed-point value
//   (FRAC_BITS fractional bits) to an IEEE-754 single-precision float.
//   Normalisation shifts one bit per cycle; rounding is round-to-nearest-even.
//   Uses a four-phase request/acknowledge handshake.
//
// Ports
//   CLK           system clock, rising edge
//   RST_FF        synchronous active-high reset
//   Begin_FSM_FF  conversion request (level), sampled only in IDLE
//   FIXED         fixed-point operand
//   ACK_FF        conversion done, registered, high only in DONE
//   RESULT        single-precision result, registered, held until next write
module fixed_to_float_seq #(
    parameter int FRAC_BITS = 26
) (
    input  logic        CLK,
    input  logic        RST_FF,
    input  logic        Begin_FSM_FF,
    input  logic [31:0] FIXED,
    output logic        ACK_FF,
    output logic [31:0] RESULT
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS   = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] op;
    logic        sign;
    logic [31:0] mag;
    logic [5:0]  lz;

    // Rounding datapath, evaluated from the normalised magnitude
    logic [7:0]  exp_base;
    logic [7:0]  exp_final;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] mant_sum;

    always_comb begin
        exp_base  = 8'd158 - {2'b00, lz} - 8'(FRAC_BITS);
        guard     = mag[7];
        sticky    = |mag[6:0];
        round_up  = guard && (sticky || mag[8]);
        mant_sum  = {1'b0, mag[30:8]} + {23'd0, round_up};
        // A carry out of the mantissa leaves mant_sum[22:0] at zero already
        exp_final = exp_base + {7'd0, mant_sum[23]};
    end

    always_ff @(posedge CLK) begin
        if (RST_FF) begin
            state  <= IDLE;
            ACK_FF <= 1'b0;
            RESULT <= '0;
            op     <= '0;
            sign   <= 1'b0;
            mag    <= '0;
            lz     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ACK_FF <= 1'b0;
                    if (Begin_FSM_FF) begin
                        op    <= FIXED;
                        state <= ABS;
                    end
                end

                ABS: begin
                    sign  <= op[31];
                    mag   <= op[31] ? (~op + 32'd1) : op;
                    lz    <= '0;
                    state <= NORM;
                end

                NORM: begin
                    // The zero test is made on the registered magnitude,
                    // which gives zero operands their two-edge latency.
                    if (mag == '0) begin
                        RESULT <= '0;
                        ACK_FF <= 1'b1;
                        state  <= DONE;
                    end else if (mag[31]) begin
                        state <= ROUND;
                    end else begin
                        mag <= {mag[30:0], 1'b0};
                        lz  <= lz + 6'd1;
                    end
                end

                ROUND: begin
                    RESULT <= {sign, exp_final, mant_sum[22:0]};
                    ACK_FF <= 1'b1;
                    state  <= DONE;
                end

                DONE: begin
                    if (!Begin_FSM_FF) begin
                        ACK_FF <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: begin
                    ACK_FF <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_to_float_seq.sv
// tb_fixed_to_float_seq
//   Directed, table-driven bench for fixed_to_float_seq with FRAC_BITS=26.
//   Each table row holds an operand, the expected float result and the
//   expected number of edges from the Begin-sampling edge to ACK rising.
module tb_fixed_to_float_seq;

    logic        CLK;
    logic        RST_FF;
    logic        Begin_FSM_FF;
    logic [31:0] FIXED;
    logic        ACK_FF;
    logic [31:0] RESULT;

    int unsigned n_cmp;
    int unsigned n_bad;

    fixed_to_float_seq #(.FRAC_BITS(26)) dut (
        .CLK          (CLK),
        .RST_FF       (RST_FF),
        .Begin_FSM_FF (Begin_FSM_FF),
        .FIXED        (FIXED),
        .ACK_FF       (ACK_FF),
        .RESULT       (RESULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] fixed;
        logic [31:0] result;
        int          latency;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Called just after a rising edge; leaves just after a rising edge.
    task automatic convert(input string name, input logic [31:0] fx,
                           input logic [31:0] exp_res, input int exp_lat);
        int lat;
        lat = 0;
        FIXED        = fx;
        Begin_FSM_FF = 1'b1;
        @(posedge CLK);            // edge k: request sampled
        #1;
        Begin_FSM_FF = 1'b0;
        FIXED        = 32'hDEAD_BEEF; // must be ignored from here on
        for (int n = 1; n <= 60; n++) begin
            @(posedge CLK);
            #1;
            if (ACK_FF === 1'b1) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: no ACK within 60 edges", name);
        end else begin
            check({name, " latency"}, 32'(lat), 32'(exp_lat));
            check({name, " result"}, RESULT, exp_res);
            @(posedge CLK);
            #1;
            check({name, " ack_drop"}, {31'd0, ACK_FF}, 32'd0);
            check({name, " hold"}, RESULT, exp_res);
        end
    endtask

    initial begin
        int acks;
        logic prev_ack;

        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = '{32'h0400_0000, 32'h3F80_0000, 8};   // 1.0
        vecs[1]  = '{32'hFC00_0000, 32'hBF80_0000, 8};   // -1.0
        vecs[2]  = '{32'h8000_0000, 32'hC200_0000, 3};   // -32, lz=0
        vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 2};   // zero
        vecs[4]  = '{32'h4000_0040, 32'h4180_0000, 4};   // tie, even
        vecs[5]  = '{32'h4000_00C0, 32'h4180_0002, 4};   // tie, odd
        vecs[6]  = '{32'h7FFF_FFFF, 32'h4200_0000, 4};   // mantissa carry-out
        vecs[7]  = '{32'h0000_0001, 32'h3280_0000, 34};  // lz=31
        vecs[8]  = '{32'h0800_0000, 32'h4000_0000, 7};   // 2.0
        vecs[9]  = '{32'hFFFF_FFFF, 32'hB280_0000, 34};  // -2^-26
        vecs[10] = '{32'h0600_0000, 32'h3FC0_0000, 8};   // 1.5

        RST_FF       = 1'b1;
        Begin_FSM_FF = 1'b0;
        FIXED        = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset ack", {31'd0, ACK_FF}, 32'd0);
        check("reset result", RESULT, 32'd0);
        RST_FF = 1'b0;

        foreach (vecs[i])
            convert($sformatf("vec%0d", i), vecs[i].fixed, vecs[i].result,
                    vecs[i].latency);

        // Begin held high for 50 cycles: exactly one conversion
        FIXED        = 32'h0800_0000;
        Begin_FSM_FF = 1'b1;
        acks         = 0;
        prev_ack     = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(posedge CLK);
            #1;
            if (n == 2) FIXED = 32'h0400_0000;
            if (ACK_FF && !prev_ack) acks++;
            prev_ack = ACK_FF;
        end
        check("hold one_rise", 32'(acks), 32'd1);
        check("hold ack_high", {31'd0, ACK_FF}, 32'd1);
        check("hold result", RESULT, 32'h4000_0000);
        Begin_FSM_FF = 1'b0;
        #2;
        check("hold ack_before_edge", {31'd0, ACK_FF}, 32'd1);
        @(posedge CLK);
        #1;
        check("hold ack_after_fall", {31'd0, ACK_FF}, 32'd0);
        @(posedge CLK);
        #1;
        check("hold no_restart", {31'd0, ACK_FF}, 32'd0);

        // Reset in the middle of normalisation
        FIXED        = 32'h0000_0001;
        Begin_FSM_FF = 1'b1;
        @(posedge CLK);
        #1;
        Begin_FSM_FF = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        check("midrst busy", {31'd0, ACK_FF}, 32'd0);
        RST_FF = 1'b1;
        @(posedge CLK);
        #1;
        RST_FF = 1'b0;
        check("midrst ack", {31'd0, ACK_FF}, 32'd0);
        check("midrst result", RESULT, 32'd0);
        // The aborted conversion must not complete later
        repeat (30) @(posedge CLK);
        #1;
        check("midrst no_ack", {31'd0, ACK_FF}, 32'd0);
        check("midrst result_kept", RESULT, 32'd0);

        // Reset then request on the very next edge
        RST_FF = 1'b1;
        @(posedge CLK);
        #1;
        RST_FF = 1'b0;
        convert("post_reset", 32'h0400_0000, 32'h3F80_0000, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
